// File: rtl/cdb_arbiter_buffered_pkg.sv
// Shared definitions for the buffered common data bus: result payload layout,
// datapath widths and default sizing of the arbiter.
package cdb_arbiter_buffered_pkg;

    localparam int XLEN              = 32;
    localparam int ROB_TAG_W         = 5;
    localparam int FU_NUM_DEFAULT    = 5;
    localparam int CDB_WIDTH_DEFAULT = 2;
    localparam int BUF_DEPTH_DEFAULT = 2;

    // Result produced by a functional unit and broadcast on the CDB.
    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic [ROB_TAG_W-1:0] ROB_tag;
    } result_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// One per-FU result FIFO. Push and pop may happen in the same cycle; the new
// entry lands behind the current head. The parent only pushes when count is
// below DEPTH and only pops when count is non-zero. Flush empties the FIFO and
// wins over any push or pop in the same cycle.
module cdb_fu_fifo
    import cdb_arbiter_buffered_pkg::*;
#(
    parameter  int DEPTH = BUF_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  result_t          push_data,
    input  logic             pop,
    output result_t          head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = idx_width(DEPTH);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter_buffered.sv
// Multi-lane common data bus. Each FU writes results into its own small FIFO;
// a round-robin scan over the FIFO heads grants up to CDB_WIDTH of them per
// cycle and the winners are broadcast from registers one cycle later.
//
// Handshake: an FU result is taken at a rising edge exactly when fu_valid[i]
// and fu_ready[i] are both high in that cycle. fu_ready[i] comes only from the
// registered FIFO count, so it never depends on fu_valid or on a same-cycle
// pop. While fu_ready[i] is low the FU must hold fu_valid and fu_result.
module cdb_arbiter_buffered
    import cdb_arbiter_buffered_pkg::*;
#(
    parameter  int FU_NUM    = FU_NUM_DEFAULT,
    parameter  int CDB_WIDTH = CDB_WIDTH_DEFAULT,
    parameter  int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    localparam int IDX_W     = idx_width(FU_NUM),
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic    [FU_NUM-1:0]                 fu_valid,
    input  result_t [FU_NUM-1:0]                 fu_result,
    output logic    [FU_NUM-1:0]                 fu_ready,
    output logic    [CDB_WIDTH-1:0]              cdb_valid,
    output result_t [CDB_WIDTH-1:0]              cdb_result,
    output logic    [CDB_WIDTH-1:0][ROB_TAG_W-1:0] cdb_ROB_tag,
    output logic    [CDB_WIDTH-1:0][XLEN-1:0]    cdb_value,
    output logic    [CDB_WIDTH-1:0][IDX_W-1:0]   cdb_fu_idx
);

    result_t          fifo_head  [FU_NUM];
    logic [CNT_W-1:0] fifo_count [FU_NUM];
    logic [FU_NUM-1:0] fifo_push;
    logic [FU_NUM-1:0] fifo_empty;
    logic [FU_NUM-1:0] grant;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     rr_next;
    logic [IDX_W:0]       scan_sum;
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     last_idx;
    logic                 any_grant;
    logic [CDB_WIDTH-1:0] lane_valid;
    logic [IDX_W-1:0]     lane_idx [CDB_WIDTH];
    int                   taken;

    for (genvar i = 0; i < FU_NUM; i++) begin : g_fu
        assign fu_ready[i]   = (fifo_count[i] < CNT_W'(BUF_DEPTH));
        assign fifo_empty[i] = (fifo_count[i] == '0);
        assign fifo_push[i]  = fu_valid[i] & fu_ready[i];

        cdb_fu_fifo #(
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .push      (fifo_push[i]),
            .push_data (fu_result[i]),
            .pop       (grant[i]),
            .head      (fifo_head[i]),
            .count     (fifo_count[i])
        );
    end

    // Round-robin scan from rr_ptr: the n-th non-empty FIFO found goes to lane n.
    // Each FIFO is visited once, so an FU never gets two lanes in one cycle.
    always_comb begin
        grant      = '0;
        lane_valid = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_idx[k] = '0;
        end
        last_idx  = rr_ptr;
        any_grant = 1'b0;
        taken     = 0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int j = 0; j < FU_NUM; j++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(j);
            if (scan_sum >= (IDX_W + 1)'(FU_NUM)) begin
                scan_sum = scan_sum - (IDX_W + 1)'(FU_NUM);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!fifo_empty[scan_idx] && (taken < CDB_WIDTH)) begin
                grant[scan_idx] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (taken == k) begin
                        lane_valid[k] = 1'b1;
                        lane_idx[k]   = scan_idx;
                    end
                end
                last_idx  = scan_idx;
                any_grant = 1'b1;
                taken     = taken + 1;
            end
        end
    end

    // Next scan starts just past the last FU that won this cycle.
    assign rr_next = (last_idx == IDX_W'(FU_NUM - 1)) ? '0 : last_idx + 1'b1;

    // Broadcast registers and round-robin pointer; idle lanes carry all zeros.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_result <= '0;
            cdb_fu_idx <= '0;
        end else if (flush) begin
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_result <= '0;
            cdb_fu_idx <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
            cdb_valid <= lane_valid;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_result[k] <= lane_valid[k] ? fifo_head[lane_idx[k]] : '0;
                cdb_fu_idx[k] <= lane_idx[k];
            end
        end
    end

    for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
        assign cdb_ROB_tag[k] = cdb_result[k].ROB_tag;
        assign cdb_value[k]   = cdb_result[k].value;
    end

endmodule

// File: tb/tb_cdb_arbiter_buffered.sv
// Bench for cdb_arbiter_buffered: a 5-FU / 2-lane instance driven from a
// table of per-cycle vectors plus directed flush, wrap and reset sequences,
// and a 5-FU / 1-lane instance streamed from two FUs under backpressure.
module tb_cdb_arbiter_buffered;
    import cdb_arbiter_buffered_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic clock;
    logic reset;
    logic flush;

    logic    [4:0]      fu_valid;
    result_t [4:0]      fu_result;
    logic    [4:0]      fu_ready;
    logic    [1:0]      cdb_valid;
    result_t [1:0]      cdb_result;
    logic    [1:0][4:0] cdb_ROB_tag;
    logic    [1:0][31:0] cdb_value;
    logic    [1:0][2:0] cdb_fu_idx;

    logic    [4:0]      b_valid;
    result_t [4:0]      b_result;
    logic    [4:0]      b_ready;
    logic    [0:0]      b_cdb_valid;
    result_t [0:0]      b_cdb_result;
    logic    [0:0][4:0] b_cdb_ROB_tag;
    logic    [0:0][31:0] b_cdb_value;
    logic    [0:0][2:0] b_cdb_fu_idx;

    int total;
    int bad;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    cdb_arbiter_buffered #(
        .FU_NUM    (5),
        .CDB_WIDTH (2),
        .BUF_DEPTH (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_result   (fu_result),
        .fu_ready    (fu_ready),
        .cdb_valid   (cdb_valid),
        .cdb_result  (cdb_result),
        .cdb_ROB_tag (cdb_ROB_tag),
        .cdb_value   (cdb_value),
        .cdb_fu_idx  (cdb_fu_idx)
    );

    cdb_arbiter_buffered #(
        .FU_NUM    (5),
        .CDB_WIDTH (1),
        .BUF_DEPTH (2)
    ) dut_one_lane (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .fu_valid    (b_valid),
        .fu_result   (b_result),
        .fu_ready    (b_ready),
        .cdb_valid   (b_cdb_valid),
        .cdb_result  (b_cdb_result),
        .cdb_ROB_tag (b_cdb_ROB_tag),
        .cdb_value   (b_cdb_value),
        .cdb_fu_idx  (b_cdb_fu_idx)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  valid;
        logic [4:0]  tag_base;
        logic [31:0] val_base;
        logic [1:0]  exp_valid;
        logic [2:0]  exp_idx0;
        logic [2:0]  exp_idx1;
        logic [4:0]  exp_tag0;
        logic [4:0]  exp_tag1;
        logic [31:0] exp_val0;
        logic [31:0] exp_val1;
        logic [4:0]  exp_ready;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic [4:0] valid, input logic [4:0] tag_base,
                                input logic [31:0] val_base, input logic [1:0] ev,
                                input logic [2:0] i0, input logic [2:0] i1,
                                input logic [4:0] t0, input logic [4:0] t1,
                                input logic [31:0] v0, input logic [31:0] v1,
                                input logic [4:0] er);
        vec_t v;
        v.valid = valid;    v.tag_base = tag_base; v.val_base = val_base;
        v.exp_valid = ev;   v.exp_idx0 = i0;       v.exp_idx1 = i1;
        v.exp_tag0 = t0;    v.exp_tag1 = t1;       v.exp_val0 = v0;
        v.exp_val1 = v1;    v.exp_ready = er;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_fu(input int i, input logic [4:0] tag, input logic [31:0] val);
        fu_result[i].ROB_tag = tag;
        fu_result[i].value   = val;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp(input logic [2:0] fu);
        if (fu == 3'd0) begin
            if (exp_q0.size() == 0) return 32'hFFFF_FFFF;
            return exp_q0.pop_front();
        end
        if (exp_q1.size() == 0) return 32'hFFFF_FFFF;
        return exp_q1.pop_front();
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int seq0;
        int seq1;
        int alt;
        int not_ready_cnt;
        logic [4:0]  acc;
        logic [31:0] exp_v;

        total = 0;
        bad   = 0;

        //      valid     tb  vbase        ev     i0 i1  t0  t1  v0           v1           ready
        vecs[0]  = mk(5'b11111, 1,  32'h100,  2'b00, 0, 0, 0,  0,  32'h0,    32'h0,    5'b11111);
        vecs[1]  = mk(5'b00000, 0,  32'h0,    2'b11, 0, 1, 1,  2,  32'h100,  32'h101,  5'b11111);
        vecs[2]  = mk(5'b00000, 0,  32'h0,    2'b11, 2, 3, 3,  4,  32'h102,  32'h103,  5'b11111);
        vecs[3]  = mk(5'b00000, 0,  32'h0,    2'b01, 4, 0, 5,  0,  32'h104,  32'h0,    5'b11111);
        vecs[4]  = mk(5'b00100, 5,  32'hDEAB, 2'b00, 0, 0, 0,  0,  32'h0,    32'h0,    5'b11111);
        vecs[5]  = mk(5'b00000, 0,  32'h0,    2'b01, 2, 0, 7,  0,  32'hDEAD, 32'h0,    5'b11111);
        vecs[6]  = mk(5'b00000, 0,  32'h0,    2'b00, 0, 0, 0,  0,  32'h0,    32'h0,    5'b11111);
        vecs[7]  = mk(5'b11111, 8,  32'h200,  2'b00, 0, 0, 0,  0,  32'h0,    32'h0,    5'b11111);
        vecs[8]  = mk(5'b11111, 13, 32'h210,  2'b11, 3, 4, 11, 12, 32'h203,  32'h204,  5'b11000);
        vecs[9]  = mk(5'b11111, 18, 32'h220,  2'b11, 0, 1, 8,  9,  32'h200,  32'h201,  5'b00011);
        vecs[10] = mk(5'b00000, 0,  32'h0,    2'b11, 2, 3, 10, 16, 32'h202,  32'h213,  5'b01111);
        vecs[11] = mk(5'b00000, 0,  32'h0,    2'b11, 4, 0, 17, 13, 32'h214,  32'h210,  5'b11111);
        vecs[12] = mk(5'b00000, 0,  32'h0,    2'b11, 1, 2, 14, 15, 32'h211,  32'h212,  5'b11111);
        vecs[13] = mk(5'b00000, 0,  32'h0,    2'b11, 3, 4, 21, 22, 32'h223,  32'h224,  5'b11111);
        vecs[14] = mk(5'b00000, 0,  32'h0,    2'b00, 0, 0, 0,  0,  32'h0,    32'h0,    5'b11111);

        reset     = 1'b1;
        flush     = 1'b0;
        fu_valid  = '0;
        fu_result = '0;
        b_valid   = '0;
        b_result  = '0;

        // Reset state
        #2;
        check("rst_cdb_valid", cdb_valid, 2'b00);
        check("rst_cdb_result", cdb_result, '0);
        check("rst_cdb_fu_idx", cdb_fu_idx, '0);
        check("rst_fu_ready", fu_ready, 5'b11111);
        check("rst_b_ready", b_ready, 5'b11111);
        tick();
        reset = 1'b0;

        // Table: all-contend, single result, fill-to-full with backpressure
        for (int r = 0; r < 15; r++) begin
            fu_valid = vecs[r].valid;
            for (int i = 0; i < 5; i++) begin
                drive_fu(i, 5'(vecs[r].tag_base + 5'(i)), vecs[r].val_base + 32'(i));
            end
            tick();
            check($sformatf("vec%0d_valid", r), cdb_valid, vecs[r].exp_valid);
            check($sformatf("vec%0d_idx0", r), cdb_fu_idx[0], vecs[r].exp_idx0);
            check($sformatf("vec%0d_idx1", r), cdb_fu_idx[1], vecs[r].exp_idx1);
            check($sformatf("vec%0d_tag0", r), cdb_ROB_tag[0], vecs[r].exp_tag0);
            check($sformatf("vec%0d_tag1", r), cdb_ROB_tag[1], vecs[r].exp_tag1);
            check($sformatf("vec%0d_val0", r), cdb_value[0], vecs[r].exp_val0);
            check($sformatf("vec%0d_val1", r), cdb_value[1], vecs[r].exp_val1);
            check($sformatf("vec%0d_ready", r), fu_ready, vecs[r].exp_ready);
        end
        fu_valid = '0;

        // Flush with three FUs holding entries
        fu_valid = 5'b00111;
        for (int i = 0; i < 3; i++) drive_fu(i, 5'(1 + i), 32'h400 + 32'(i));
        tick();
        check("fl_pre_valid0", cdb_valid, 2'b00);
        for (int i = 0; i < 3; i++) drive_fu(i, 5'(4 + i), 32'h410 + 32'(i));
        tick();
        check("fl_pre_valid1", cdb_valid, 2'b11);
        check("fl_pre_tags", {cdb_result[1].ROB_tag, cdb_result[0].ROB_tag}, {5'd2, 5'd1});
        flush = 1'b1;
        for (int i = 0; i < 3; i++) drive_fu(i, 5'(7 + i), 32'h420 + 32'(i));
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        check("fl_valid", cdb_valid, 2'b00);
        check("fl_ready", fu_ready, 5'b11111);
        check("fl_result", cdb_result, '0);
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("fl_idle%0d_valid", n), cdb_valid, 2'b00);
        end
        fu_valid = 5'b10001;
        drive_fu(0, 5'd10, 32'h430);
        drive_fu(4, 5'd11, 32'h434);
        tick();
        fu_valid = '0;
        check("fl_post_lat1", cdb_valid, 2'b00);
        tick();
        check("fl_post_valid", cdb_valid, 2'b11);
        check("fl_post_idx", {cdb_fu_idx[1], cdb_fu_idx[0]}, {3'd4, 3'd0});
        check("fl_post_tags", {cdb_result[1].ROB_tag, cdb_result[0].ROB_tag}, {5'd11, 5'd10});
        tick();
        check("fl_post_idle", cdb_valid, 2'b00);

        // FU3 streams 8 results through its 2-deep FIFO
        for (int k = 0; k < 10; k++) begin
            fu_valid = (k < 8) ? 5'b01000 : 5'b00000;
            drive_fu(3, 5'(k + 1), 32'h300 + 32'(k + 1));
            tick();
            check($sformatf("wr%0d_ready3", k), fu_ready[3], 1'b1);
            if (k >= 1 && k <= 8) begin
                check($sformatf("wr%0d_valid", k), cdb_valid, 2'b01);
                check($sformatf("wr%0d_idx", k), cdb_fu_idx[0], 3'd3);
                check($sformatf("wr%0d_tag", k), cdb_result[0].ROB_tag, 5'(k));
                check($sformatf("wr%0d_val", k), cdb_result[0].value, 32'h300 + 32'(k));
            end else begin
                check($sformatf("wr%0d_valid", k), cdb_valid, 2'b00);
            end
        end
        fu_valid = '0;

        // Asynchronous reset between edges while buffers hold results
        fu_valid = 5'b00111;
        for (int i = 0; i < 3; i++) drive_fu(i, 5'(1 + i), 32'h500 + 32'(i));
        tick();
        fu_valid = '0;
        tick();
        check("rs_pre_valid", cdb_valid, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        check("rs_valid", cdb_valid, 2'b00);
        check("rs_result", cdb_result, '0);
        check("rs_idx", cdb_fu_idx, '0);
        check("rs_ready", fu_ready, 5'b11111);
        tick();
        reset = 1'b0;
        tick();
        check("rs_after_idle", cdb_valid, 2'b00);
        fu_valid = 5'b00010;
        drive_fu(1, 5'd3, 32'h55);
        tick();
        fu_valid = '0;
        check("rs_lat1", cdb_valid, 2'b00);
        tick();
        check("rs_lat2_valid", cdb_valid, 2'b01);
        check("rs_lat2_idx", cdb_fu_idx[0], 3'd1);
        check("rs_lat2_tag", cdb_result[0].ROB_tag, 5'd3);
        check("rs_lat2_val", cdb_result[0].value, 32'h55);
        tick();
        check("rs_lat3_valid", cdb_valid, 2'b00);

        // One lane, FU0 and FU1 always valid: alternating grants, backpressure
        seq0 = 0;
        seq1 = 0;
        alt  = 0;
        not_ready_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            b_valid = 5'b00011;
            b_result[0].ROB_tag = 5'd0;
            b_result[0].value   = 32'hA000_0000 | 32'(seq0);
            b_result[1].ROB_tag = 5'd1;
            b_result[1].value   = 32'hB000_0000 | 32'(seq1);
            acc = b_ready & b_valid;
            if (acc[0]) exp_q0.push_back(b_result[0].value);
            if (acc[1]) exp_q1.push_back(b_result[1].value);
            if (b_ready[1:0] != 2'b11) not_ready_cnt++;
            tick();
            if (acc[0]) seq0++;
            if (acc[1]) seq1++;
            check($sformatf("bp%0d_valid", c), b_cdb_valid, (c >= 1) ? 1'b1 : 1'b0);
            if (b_cdb_valid[0]) begin
                check($sformatf("bp%0d_idx", c), b_cdb_fu_idx[0], 3'(alt));
                alt = 1 - alt;
                exp_v = pop_exp(b_cdb_fu_idx[0]);
                check($sformatf("bp%0d_value", c), b_cdb_value[0], exp_v);
            end
        end
        b_valid = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b_cdb_valid[0]) begin
                exp_v = pop_exp(b_cdb_fu_idx[0]);
                check($sformatf("bp_drain%0d_value", c), b_cdb_value[0], exp_v);
            end
        end
        check("bp_q0_empty", exp_q0.size(), 0);
        check("bp_q1_empty", exp_q1.size(), 0);
        check("bp_ready_dropped", (not_ready_cnt > 0) ? 1'b1 : 1'b0, 1'b1);
        check("bp_final_ready", b_ready, 5'b11111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
